// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU control codes and the ID/EX pipeline register layout
// for the id_ex_stage block.
package id_ex_stage_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int ALU_W  = 5;

  typedef enum logic [ALU_W-1:0] {
    ALU_SLL  = 5'b00000,
    ALU_SRL  = 5'b00001,
    ALU_SRA  = 5'b00010,
    ALU_SLLV = 5'b00011,
    ALU_SRLV = 5'b00100,
    ALU_SRAV = 5'b00101,
    ALU_ADD  = 5'b00110,
    ALU_ADDU = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SUBU = 5'b01001,
    ALU_AND  = 5'b01010,
    ALU_OR   = 5'b01011,
    ALU_XOR  = 5'b01100,
    ALU_NOR  = 5'b01101,
    ALU_SLT  = 5'b01110,
    ALU_SLTU = 5'b01111,
    ALU_LUI  = 5'b10000
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs_num;
    logic [REG_W-1:0]  rt_num;
    logic [REG_W-1:0]  rd_num;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [ALU_W-1:0]  alu_control;
    logic [REG_W-1:0]  shamt;
    logic              is_load;
    logic              reg_write;
  } ex_reg_t;

  // A writer hits a source only when it writes, the numbers match and the source is not r0.
  function automatic logic reg_hit(logic wr, logic [REG_W-1:0] rd, logic [REG_W-1:0] src);
    return wr && (rd == src) && (src != '0);
  endfunction

  function automatic logic src_dep(logic wr, logic [REG_W-1:0] rd,
                                   logic [REG_W-1:0] rs, logic rs_used,
                                   logic [REG_W-1:0] rt, logic rt_used);
    return (rs_used && reg_hit(wr, rd, rs)) || (rt_used && reg_hit(wr, rd, rt));
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: ID instruction fields in, stall and EX operands out.
// id_valid/!stall_id form a valid/ready pair: an ID instruction transfers on an
// edge with id_valid=1, stall_id=0 and flush=0; while stall_id=1 ID must hold.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic              id_valid;
  logic [REG_W-1:0]  id_rs_num;
  logic [REG_W-1:0]  id_rt_num;
  logic [REG_W-1:0]  id_rd_num;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [ALU_W-1:0]  id_alu_control;
  logic [REG_W-1:0]  id_shamt;
  logic              id_is_load;
  logic              id_reg_write;
  logic              flush;

  logic              stall_id;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs;
  logic [DATA_W-1:0] ex_rt;
  logic [ALU_W-1:0]  ex_alu_control;
  logic [REG_W-1:0]  ex_shamt;
  logic [REG_W-1:0]  ex_rd_num;
  logic              ex_reg_write;
  logic              ex_is_load;

  modport master (
    output id_valid, id_rs_num, id_rt_num, id_rd_num, id_rs_val, id_rt_val, id_imm,
           id_use_imm, id_rs_used, id_rt_used, id_alu_control, id_shamt, id_is_load,
           id_reg_write, flush,
    input  stall_id, ex_valid, ex_rs, ex_rt, ex_alu_control, ex_shamt, ex_rd_num,
           ex_reg_write, ex_is_load
  );

  modport slave (
    input  id_valid, id_rs_num, id_rt_num, id_rd_num, id_rs_val, id_rt_val, id_imm,
           id_use_imm, id_rs_used, id_rt_used, id_alu_control, id_shamt, id_is_load,
           id_reg_write, flush,
    output stall_id, ex_valid, ex_rs, ex_rt, ex_alu_control, ex_shamt, ex_rd_num,
           ex_reg_write, ex_is_load
  );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding mux for one EX source: EX/MEM beats MEM/WB beats the
// registered value. EN=0 passes the registered value straight through.
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [REG_W-1:0]  src_i,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] reg_val_i,
  input  logic [REG_W-1:0]  exmem_rd_i,
  input  logic              exmem_reg_write_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic [REG_W-1:0]  memwb_rd_i,
  input  logic              memwb_reg_write_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic [DATA_W-1:0] val_o
);

  always_comb begin
    val_o = reg_val_i;
    if (EN && src_valid_i) begin
      if (reg_hit(exmem_reg_write_i, exmem_rd_i, src_i)) begin
        val_o = exmem_result_i;
      end else if (reg_hit(memwb_reg_write_i, memwb_rd_i, src_i)) begin
        val_o = memwb_result_i;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and operand forwarding.
// FORWARD_EN defined: forward from EX/MEM and MEM/WB, stall only on load-use.
// FORWARD_EN undefined: no forwarding, stall on any pending writer of a source.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_if.slave      bus,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] memwb_result
);

`ifdef FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  ex_reg_t           ex_q, ex_d;
  logic              dep_ex, hazard, stall, issue;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // A bubble in EX never counts as a writer.
  assign dep_ex = src_dep(ex_q.valid && ex_q.reg_write, ex_q.rd_num,
                          bus.id_rs_num, bus.id_rs_used, bus.id_rt_num, bus.id_rt_used);

`ifdef FORWARD_EN
  assign hazard = dep_ex && ex_q.is_load;
`else
  logic dep_exmem, dep_memwb;
  assign dep_exmem = src_dep(exmem_reg_write, exmem_rd,
                             bus.id_rs_num, bus.id_rs_used, bus.id_rt_num, bus.id_rt_used);
  assign dep_memwb = src_dep(memwb_reg_write, memwb_rd,
                             bus.id_rs_num, bus.id_rs_used, bus.id_rt_num, bus.id_rt_used);
  assign hazard = dep_ex || dep_exmem || dep_memwb;
`endif

  assign stall = !rst && !bus.flush && bus.id_valid && hazard;
  assign issue = bus.id_valid && !bus.flush && !stall;

  always_comb begin
    ex_d             = '0;
    ex_d.valid       = issue;
    ex_d.rs_num      = bus.id_rs_num;
    ex_d.rt_num      = bus.id_rt_num;
    ex_d.rd_num      = bus.id_rd_num;
    ex_d.rs_val      = bus.id_rs_val;
    ex_d.rt_val      = bus.id_rt_val;
    ex_d.imm         = bus.id_imm;
    ex_d.use_imm     = bus.id_use_imm;
    ex_d.alu_control = bus.id_alu_control;
    ex_d.shamt       = bus.id_shamt;
    ex_d.is_load     = issue && bus.id_is_load;
    ex_d.reg_write   = issue && bus.id_reg_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_unit #(.EN(FwdEn)) u_fwd_rs (
    .src_i             (ex_q.rs_num),
    .src_valid_i       (ex_q.valid),
    .reg_val_i         (ex_q.rs_val),
    .exmem_rd_i        (exmem_rd),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_result_i    (exmem_result),
    .memwb_rd_i        (memwb_rd),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_result_i    (memwb_result),
    .val_o             (rs_fwd)
  );

  fwd_unit #(.EN(FwdEn)) u_fwd_rt (
    .src_i             (ex_q.rt_num),
    .src_valid_i       (ex_q.valid),
    .reg_val_i         (ex_q.rt_val),
    .exmem_rd_i        (exmem_rd),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_result_i    (exmem_result),
    .memwb_rd_i        (memwb_rd),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_result_i    (memwb_result),
    .val_o             (rt_fwd)
  );

  assign bus.stall_id       = stall;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_rs          = rs_fwd;
  assign bus.ex_rt          = ex_q.use_imm ? ex_q.imm : rt_fwd;
  assign bus.ex_alu_control = ex_q.alu_control;
  assign bus.ex_shamt       = ex_q.shamt;
  assign bus.ex_rd_num      = ex_q.rd_num;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_is_load     = ex_q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/forwarding scenarios then random traffic,
// checked against an instruction-level reference model through an expected queue.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

`ifdef FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;

  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result)
  );

  typedef struct packed {
    logic        full;
    logic        valid;
    logic        rw;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  alu;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model of the instruction sitting in EX after the next edge.
  logic       m_valid = 1'b0, m_rw = 1'b0, m_ld = 1'b0;
  logic [4:0] m_rd = 5'd0;
  logic       last_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic id_uses(input logic [4:0] r);
    return (r != 5'd0) && ((bus.id_rs_used && bus.id_rs_num == r) ||
                           (bus.id_rt_used && bus.id_rt_num == r));
  endfunction

  // Value the ALU sees for a source, given the writeback results on the bus.
  function automatic logic [31:0] ref_operand(input logic [4:0] src, input logic [31:0] val);
    if (FWD_ON && src != 5'd0 && exmem_reg_write && exmem_rd == src) return exmem_result;
    if (FWD_ON && src != 5'd0 && memwb_reg_write && memwb_rd == src) return memwb_result;
    return val;
  endfunction

  function automatic logic ref_stall();
    if (rst || bus.flush || !bus.id_valid) return 1'b0;
    if (FWD_ON) return m_valid && m_ld && m_rw && id_uses(m_rd);
    return (m_valid && m_rw && id_uses(m_rd)) ||
           (exmem_reg_write && id_uses(exmem_rd)) ||
           (memwb_reg_write && id_uses(memwb_rd));
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [31:0] imm, input logic ui, input logic rsu, input logic rtu,
                        input logic [4:0] alu, input logic [4:0] sh, input logic ld,
                        input logic rw);
    bus.id_valid = v;        bus.id_rs_num = rs;   bus.id_rt_num = rt;
    bus.id_rd_num = rd;      bus.id_rs_val = rsv;  bus.id_rt_val = rtv;
    bus.id_imm = imm;        bus.id_use_imm = ui;  bus.id_rs_used = rsu;
    bus.id_rt_used = rtu;    bus.id_alu_control = alu;
    bus.id_shamt = sh;       bus.id_is_load = ld;  bus.id_reg_write = rw;
  endtask

  task automatic set_wb(input logic [4:0] erd, input logic erw, input logic [31:0] eres,
                        input logic [4:0] mrd, input logic mrw, input logic [31:0] mres);
    exmem_rd = erd; exmem_reg_write = erw; exmem_result = eres;
    memwb_rd = mrd; memwb_reg_write = mrw; memwb_result = mres;
  endtask

  // One cycle: inputs already applied at a negedge; check stall, predict EX, advance.
  task automatic step();
    exp_t e;
    logic s, iss;
    #1;
    s = ref_stall();
    check("stall_id", {31'd0, bus.stall_id}, {31'd0, s});
    e = '0;
    if (rst) begin
      e.full = 1'b1;
    end else begin
      iss     = bus.id_valid && !bus.flush && !s;
      e.full  = iss;
      e.valid = iss;
      e.rw    = iss && bus.id_reg_write;
      e.ld    = iss && bus.id_is_load;
      e.rd    = bus.id_rd_num;
      e.alu   = bus.id_alu_control;
      e.shamt = bus.id_shamt;
      e.rs    = ref_operand(bus.id_rs_num, bus.id_rs_val);
      e.rt    = bus.id_use_imm ? bus.id_imm : ref_operand(bus.id_rt_num, bus.id_rt_val);
    end
    exp_q.push_back(e);
    m_valid = e.valid; m_rw = e.rw; m_ld = e.ld; m_rd = e.rd;
    last_stall = s;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, e.valid});
        check("ex_reg_write", {31'd0, bus.ex_reg_write}, {31'd0, e.rw});
        check("ex_is_load", {31'd0, bus.ex_is_load}, {31'd0, e.ld});
        if (e.full) begin
          check("ex_rd_num", {27'd0, bus.ex_rd_num}, {27'd0, e.rd});
          check("ex_alu_control", {27'd0, bus.ex_alu_control}, {27'd0, e.alu});
          check("ex_shamt", {27'd0, bus.ex_shamt}, {27'd0, e.shamt});
          check("ex_rs", bus.ex_rs, e.rs);
          check("ex_rt", bus.ex_rt, e.rt);
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    bus.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    // Reset with a live instruction presented: it must be discarded.
    step();
    set_id(1, 1, 2, 3, 32'h1234, 32'h5678, 0, 0, 1, 1, ALU_ADD, 0, 0, 1);
    step();
    rst = 1'b0;

    // EX/MEM forwarding onto rs.
    set_wb(3, 1, 32'h10, 0, 0, 0);
    set_id(1, 3, 0, 7, 32'h1111, 32'h2222, 0, 0, 1, 0, ALU_ADD, 0, 0, 1);
    step();
    set_wb(0, 0, 0, 0, 0, 0);
    step();

    // Forwarding priority on rt, then MEM/WB alone.
    set_wb(5, 1, 32'hAA, 5, 1, 32'hBB);
    set_id(1, 0, 5, 8, 0, 32'h55, 0, 0, 0, 1, ALU_OR, 0, 0, 1);
    step();
    set_wb(0, 1, 32'hAA, 5, 1, 32'hBB);
    step();
    set_wb(0, 0, 0, 0, 0, 0);
    step();

    // Load-use: lw r4 then a consumer of r4; load data arrives through MEM/WB.
    set_id(1, 0, 0, 4, 0, 0, 32'h40, 1, 0, 0, ALU_ADD, 0, 1, 1);
    step();
    set_id(1, 4, 0, 9, 32'h9999, 0, 0, 0, 1, 0, ALU_SUB, 5'd3, 0, 1);
    step();
    set_wb(0, 0, 0, 4, 1, 32'h44);
    step();
    set_wb(0, 0, 0, 0, 0, 0);
    step();

    // Flush while a load-use stall is pending.
    set_id(1, 0, 0, 4, 0, 0, 32'h40, 1, 0, 0, ALU_ADD, 0, 1, 1);
    step();
    set_id(1, 4, 4, 10, 32'h7, 32'h8, 0, 0, 1, 1, ALU_AND, 0, 0, 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // r0 never forwards; immediate replaces rt and blocks rt forwarding.
    set_wb(0, 1, 32'hDEAD, 0, 1, 32'hBEEF);
    set_id(1, 0, 0, 11, 32'h0, 32'h0, 0, 0, 1, 1, ALU_XOR, 0, 0, 1);
    step();
    set_wb(5, 1, 32'hCAFE, 0, 0, 0);
    set_id(1, 0, 5, 12, 32'h3, 32'h77, 32'hFFFF0000, 1, 0, 0, ALU_LUI, 0, 0, 1);
    step();
    set_wb(0, 0, 0, 0, 0, 0);

    // RAW on r6 as the producer walks EX -> EX/MEM -> MEM/WB -> retired.
    set_id(1, 1, 2, 6, 32'h1, 32'h2, 0, 0, 1, 1, ALU_ADD, 0, 0, 1);
    step();
    set_id(1, 6, 0, 13, 32'h66, 0, 0, 0, 1, 0, ALU_SLT, 0, 0, 1);
    step();
    set_wb(6, 1, 32'h600, 0, 0, 0);
    step();
    set_wb(0, 0, 0, 6, 1, 32'h601);
    step();
    set_wb(0, 0, 0, 0, 0, 0);
    step();

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      if (!last_stall || rst) begin
        set_id(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 16)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      set_wb(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
      step();
    end
    rst = 1'b0;
    bus.flush = 1'b0;

    @(posedge clk);
    #2;
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
